txstr: RTL and testbench

//   Serial string transmitter: after reset is released, sends a fixed 8-character

---
 rtl/txstr_pkg.sv | 42 ++++
 rtl/txstr_uart_tx.sv | 54 +++++
 rtl/txstr.sv | 65 ++++++
 tb/tb_txstr.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/txstr_pkg.sv
// Shared constants for the string transmitter: baud divisors for a 12 MHz clock,
// the sequencer state type and the message ROM.
package txstr_pkg;

    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B38400  = 313;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B9600   = 1250;
    localparam int unsigned B4800   = 2500;
    localparam int unsigned B2400   = 5000;
    localparam int unsigned B1200   = 10000;
    localparam int unsigned B600    = 20000;
    localparam int unsigned B300    = 40000;

    localparam int unsigned MsgLen  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StTxCar,
        StWait,
        StNext,
        StEnd
    } seq_state_t;

    // "Hello!.."
    function automatic logic [7:0] msg_rom(input logic [2:0] idx);
        logic [7:0] w_chr;
        unique case (idx)
            3'd0:    w_chr = 8'h48;
            3'd1:    w_chr = 8'h65;
            3'd2:    w_chr = 8'h6C;
            3'd3:    w_chr = 8'h6C;
            3'd4:    w_chr = 8'h6F;
            3'd5:    w_chr = 8'h21;
            3'd6:    w_chr = 8'h2E;
            default: w_chr = 8'h2E;
        endcase
        return w_chr;
    endfunction

endpackage

// File: rtl/txstr_uart_tx.sv
// 8N1 UART transmitter: a 10-bit frame shift register whose LSB drives the line,
// advanced by a baud divisor that only runs while a frame is in flight.
module txstr_uart_tx
    import txstr_pkg::*;
#(
    parameter int unsigned BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned DivW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(BAUDRATE - 1);

    logic [9:0]      r_shift;
    logic [3:0]      r_bitcnt;
    logic [DivW-1:0] r_div;
    logic            r_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift  <= '1;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_ready  <= 1'b1;
        end else if (r_ready) begin
            if (start) begin
                // Loading the frame puts the start bit on the line this edge.
                r_shift  <= {1'b1, data, 1'b0};
                r_bitcnt <= '0;
                r_div    <= '0;
                r_ready  <= 1'b0;
            end
        end else if (r_div == DivLast) begin
            r_div <= '0;
            if (r_bitcnt == 4'd9) begin
                r_ready <= 1'b1;
            end else begin
                r_shift  <= {1'b1, r_shift[9:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end
        end else begin
            r_div <= r_div + DivW'(1);
        end
    end

    assign tx    = r_shift[0];
    assign ready = r_ready;

endmodule

// File: rtl/txstr.sv
// Sends the message ROM once over the UART after each reset release, then idles
// with the line high.
module txstr
    import txstr_pkg::*;
#(
    parameter int unsigned BAUDRATE = B115200
) (
    input  logic clk,
    input  logic rstn,
    output logic tx
);

    seq_state_t r_state;
    seq_state_t w_state_d;
    logic [2:0] r_idx;
    logic [2:0] w_idx_d;
    logic       w_start;
    logic       w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle:  w_state_d = StTxCar;
            StTxCar: begin
                w_start = 1'b1;
                if (w_ready) w_state_d = StWait;
            end
            StWait:  if (w_ready) w_state_d = StNext;
            StNext: begin
                if (r_idx == 3'(MsgLen - 1)) begin
                    w_state_d = StEnd;
                end else begin
                    w_idx_d   = r_idx + 3'd1;
                    w_state_d = StTxCar;
                end
            end
            StEnd:   w_state_d = StEnd;
            default: w_state_d = StIdle;
        endcase
    end

    txstr_uart_tx #(
        .BAUDRATE(BAUDRATE)
    ) u_uart_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (w_start),
        .data  (msg_rom(r_idx)),
        .tx    (tx),
        .ready (w_ready)
    );

endmodule

// File: tb/tb_txstr.sv
// Bench for txstr: a fast instance (4 clocks/bit) and a default-rate instance,
// both decoded by a sampling UART receiver and compared with the expected text.
module tb_txstr;

    logic clk = 1'b0;
    logic rstn4 = 1'b0;
    logic rstn104 = 1'b0;
    logic tx4;
    logic tx104;
    logic sel = 1'b0;
    logic w_tx;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign w_tx = sel ? tx104 : tx4;

    txstr #(.BAUDRATE(4)) dut4 (
        .clk  (clk),
        .rstn (rstn4),
        .tx   (tx4)
    );

    txstr dut104 (
        .clk  (clk),
        .rstn (rstn104),
        .tx   (tx104)
    );

    typedef struct {
        logic [7:0] exp_byte;
        int         max_gap;
    } vec_t;

    vec_t  tbl[8];
    string msg = "Hello!..";

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Waits at negedges for the line to go low; idle counts high samples seen first.
    task automatic wait_start(input int limit, output int idle, output bit to);
        idle = 0;
        to   = 1'b0;
        @(negedge clk);
        while (w_tx !== 1'b0) begin
            idle++;
            if (idle > limit) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Called on the first low sample; samples every clock of all 10 bits.
    task automatic read_frame(input int baud, output logic [7:0] d, output logic stopb,
                              output bit stable);
        logic v;
        logic bitv;
        stable = 1'b1;
        d      = '0;
        stopb  = 1'b0;
        bitv   = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < baud; k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                v = w_tx;
                if (k == 0) bitv = v;
                else if (v !== bitv) stable = 1'b0;
            end
            if (b >= 1 && b <= 8) d[b-1] = bitv;
            if (b == 0 && bitv !== 1'b0) stable = 1'b0;
            if (b == 9) stopb = bitv;
        end
    endtask

    task automatic run_message(input int baud, input int nfr, input string tag,
                               output int total);
        int         idle;
        bit         to;
        logic [7:0] d;
        logic       stopb;
        bit         stable;
        total = 0;
        for (int i = 0; i < nfr; i++) begin
            wait_start(20, idle, to);
            chk($sformatf("%s_start_timeout_%0d", tag, i), int'(to), 0);
            if (to) return;
            read_frame(baud, d, stopb, stable);
            total += idle + 10 * baud;
            chk($sformatf("%s_byte_%0d", tag, i), int'(d), int'(tbl[i].exp_byte));
            chk($sformatf("%s_stop_%0d", tag, i), int'(stopb), 1);
            chk($sformatf("%s_bitwidth_%0d", tag, i), int'(stable), 1);
            chk($sformatf("%s_gap_ok_%0d", tag, i), int'(idle <= tbl[i].max_gap), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int   bad;
        int   total;
        int   idle;
        bit   to;
        int   offset;
        int   bitpos;
        logic [7:0] d;
        logic stopb;
        bit   stable;
        logic [7:0] ch;

        for (int i = 0; i < 8; i++) begin
            tbl[i].exp_byte = msg[i];
            tbl[i].max_gap  = 3;
        end

        // Reset held: both lines must stay high with no transitions.
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || tx104 !== 1'b1) bad++;
        end
        chk("reset_tx_high", bad, 0);

        // Full message at 4 clocks/bit, then silence.
        rstn4 = 1'b1;
        sel   = 1'b0;
        run_message(4, 8, "msg4", total);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx4 !== 1'b1) bad++;
        end
        chk("post_msg_idle", bad, 0);

        // Reset during frame 3 data bits at a random point.
        rstn4 = 1'b0;
        repeat (3) @(negedge clk);
        rstn4 = 1'b1;
        run_message(4, 2, "pre_abort", total);
        wait_start(20, idle, to);
        chk("abort_start_timeout", int'(to), 0);
        offset = 4 + int'($urandom_range(0, 31));
        repeat (offset) @(negedge clk);
        bitpos = offset / 4 - 1;
        ch = msg[2];
        chk("abort_databit", int'(tx4), int'(ch[bitpos]));
        rstn4 = 1'b0;
        #1;
        chk("abort_tx_async_high", int'(tx4), 1);
        repeat (3) @(negedge clk);
        chk("abort_tx_held_high", int'(tx4), 1);
        rstn4 = 1'b1;
        run_message(4, 8, "restart", total);

        // Default rate: bit width 104 and total duration bound.
        sel     = 1'b1;
        rstn104 = 1'b1;
        run_message(104, 8, "msg104", total);
        chk("msg104_total_ok", int'(total <= 8 * (1040 + 3) + 3), 1);
        chk("msg104_total_min", int'(total >= 8 * 1040), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
